// File: rtl/cv32e40p_instr_aligner.sv
// Splits the word-aligned fetch stream into RV32IC instructions. The upper half-word of a
// fetch word is held so that a 32-bit instruction spanning two words comes out whole.
module cv32e40p_instr_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_compressed_o,
  output logic [31:0] instr_addr_o
);

  typedef enum logic [1:0] {ALIGNED, RESIDUE, MISALIGNED} state_e;

  state_e      r_state;
  logic [31:1] r_pc;
  logic [15:0] r_residue;

  state_e      w_state_n;
  logic [31:1] w_pc_n;
  logic [15:0] w_residue_n;
  logic        w_valid;
  logic        w_fetch_ready;
  logic        w_xfer;
  logic [31:0] w_rdata;

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_residue_n   = r_residue;
    w_valid       = 1'b0;
    w_fetch_ready = 1'b0;
    w_xfer        = 1'b0;
    w_rdata       = fetch_rdata_i;

    unique case (r_state)
      ALIGNED: begin
        w_valid = fetch_valid_i;
        w_xfer  = w_valid & instr_ready_i;
        if (fetch_rdata_i[1:0] == 2'b11) begin
          w_rdata = fetch_rdata_i;
          if (w_xfer) begin
            w_fetch_ready = 1'b1;
            w_pc_n        = r_pc + 31'd2;
          end
        end else begin
          w_rdata = {16'h0000, fetch_rdata_i[15:0]};
          if (w_xfer) begin
            w_fetch_ready = 1'b1;
            w_residue_n   = fetch_rdata_i[31:16];
            w_pc_n        = r_pc + 31'd1;
            w_state_n     = RESIDUE;
          end
        end
      end
      RESIDUE: begin
        if (r_residue[1:0] != 2'b11) begin
          // A compressed residue is issued without touching the pending fetch word.
          w_valid = 1'b1;
          w_xfer  = instr_ready_i;
          w_rdata = {16'h0000, r_residue};
          if (w_xfer) begin
            w_pc_n    = r_pc + 31'd1;
            w_state_n = ALIGNED;
          end
        end else begin
          w_valid = fetch_valid_i;
          w_xfer  = w_valid & instr_ready_i;
          w_rdata = {fetch_rdata_i[15:0], r_residue};
          if (w_xfer) begin
            w_fetch_ready = 1'b1;
            w_residue_n   = fetch_rdata_i[31:16];
            w_pc_n        = r_pc + 31'd2;
          end
        end
      end
      MISALIGNED: begin
        w_rdata       = {16'h0000, r_residue};
        w_fetch_ready = fetch_valid_i;
        if (fetch_valid_i) begin
          w_residue_n = fetch_rdata_i[31:16];
          w_state_n   = RESIDUE;
        end
      end
      default: begin
        w_state_n = ALIGNED;
      end
    endcase

    if (branch_i) begin
      w_valid       = 1'b0;
      w_fetch_ready = 1'b0;
      w_pc_n        = branch_addr_i[31:1];
      w_residue_n   = 16'h0000;
      w_state_n     = branch_addr_i[1] ? MISALIGNED : ALIGNED;
    end

    if (rst) begin
      w_valid       = 1'b0;
      w_fetch_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ALIGNED;
      r_pc      <= BOOT_ADDR[31:1];
      r_residue <= 16'h0000;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_residue <= w_residue_n;
    end
  end

  assign instr_valid_o      = w_valid;
  assign fetch_ready_o      = w_fetch_ready;
  assign instr_rdata_o      = w_rdata;
  assign instr_compressed_o = (w_rdata[1:0] != 2'b11);
  assign instr_addr_o       = {r_pc, 1'b0};

endmodule

// File: tb/tb_cv32e40p_instr_aligner.sv
// Directed bench for cv32e40p_instr_aligner: a per-cycle vector table followed by
// hand-written stall/branch, wrap-around and reset-in-residue sequences.
module tb_cv32e40p_instr_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic        instr_compressed_o;
  logic [31:0] instr_addr_o;

  int n_chk  = 0;
  int n_fail = 0;

  cv32e40p_instr_aligner #(.BOOT_ADDR(32'h0000_0080)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_rdata_i      (fetch_rdata_i),
    .fetch_ready_o      (fetch_ready_o),
    .branch_i           (branch_i),
    .branch_addr_i      (branch_addr_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_rdata_o      (instr_rdata_o),
    .instr_compressed_o (instr_compressed_o),
    .instr_addr_o       (instr_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fd;
    logic        br;
    logic [31:0] ba;
    logic        ir;
    logic        ev;
    logic        efr;
    logic        chk;
    logic [31:0] ed;
    logic [31:0] ea;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  function automatic vec_t mk(logic r, logic fv, logic [31:0] fd, logic br, logic [31:0] ba,
                              logic ir, logic ev, logic efr, logic chk,
                              logic [31:0] ed, logic [31:0] ea);
    vec_t v;
    v.rst = r; v.fv = fv; v.fd = fd; v.br = br; v.ba = ba; v.ir = ir;
    v.ev = ev; v.efr = efr; v.chk = chk; v.ed = ed; v.ea = ea;
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(string nm, vec_t v);
    @(negedge clk);
    rst           = v.rst;
    fetch_valid_i = v.fv;
    fetch_rdata_i = v.fd;
    branch_i      = v.br;
    branch_addr_i = v.ba;
    instr_ready_i = v.ir;
    #1;
    cmp({nm, ".valid"}, {31'd0, instr_valid_o}, {31'd0, v.ev});
    cmp({nm, ".fready"}, {31'd0, fetch_ready_o}, {31'd0, v.efr});
    if (v.chk) begin
      cmp({nm, ".rdata"}, instr_rdata_o, v.ed);
      cmp({nm, ".addr"}, instr_addr_o, v.ea);
      cmp({nm, ".cmpr"}, {31'd0, instr_compressed_o}, {31'd0, (v.ed[1:0] != 2'b11)});
    end
  endtask

  task automatic cyc(string nm, logic r, logic fv, logic [31:0] fd, logic br, logic [31:0] ba,
                     logic ir, logic ev, logic efr, logic chk, logic [31:0] ed, logic [31:0] ea);
    apply(nm, mk(r, fv, fd, br, ba, ir, ev, efr, chk, ed, ea));
  endtask

  initial begin
    rst = 1'b1; fetch_valid_i = 1'b0; fetch_rdata_i = '0;
    branch_i = 1'b0; branch_addr_i = '0; instr_ready_i = 1'b1;

    //          rst fv  fd            br  ba            ir  ev  efr chk ed            ea
    vt[0]  = mk(1, 1, 32'h0000_0013, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0);
    vt[1]  = mk(0, 1, 32'h0000_0013, 0, 32'h0,        1, 1, 1, 1, 32'h0000_0013, 32'h80);
    vt[2]  = mk(0, 1, 32'h0010_0093, 0, 32'h0,        1, 1, 1, 1, 32'h0010_0093, 32'h84);
    vt[3]  = mk(1, 0, 32'h0,         0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0);
    vt[4]  = mk(0, 1, 32'h0001_0001, 0, 32'h0,        1, 1, 1, 1, 32'h0000_0001, 32'h80);
    vt[5]  = mk(0, 0, 32'h0001_0001, 0, 32'h0,        1, 1, 0, 1, 32'h0000_0001, 32'h82);
    vt[6]  = mk(1, 0, 32'h0,         0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0);
    vt[7]  = mk(0, 1, 32'h0013_0001, 0, 32'h0,        1, 1, 1, 1, 32'h0000_0001, 32'h80);
    vt[8]  = mk(0, 1, 32'hAAAA_0000, 0, 32'h0,        1, 1, 1, 1, 32'h0000_0013, 32'h82);
    vt[9]  = mk(0, 0, 32'h0,         0, 32'h0,        1, 1, 0, 1, 32'h0000_AAAA, 32'h86);
    vt[10] = mk(0, 0, 32'h0,         0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0);
    vt[11] = mk(0, 1, 32'h1234_5677, 1, 32'h0000_0102, 1, 0, 0, 0, 32'h0,        32'h0);
    vt[12] = mk(0, 1, 32'h0001_FFFF, 0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0);
    vt[13] = mk(0, 0, 32'h0,         0, 32'h0,        1, 1, 0, 1, 32'h0000_0001, 32'h102);

    for (int i = 0; i < NV; i++) apply($sformatf("vec%0d", i), vt[i]);

    // Back-pressure on a 32-bit word at 0x104, then a branch with ready high.
    for (int i = 0; i < 3; i++)
      cyc($sformatf("stall%0d", i), 0, 1, 32'h0010_0093, 0, 32'h0, 0, 1, 0, 1, 32'h0010_0093, 32'h104);
    cyc("br_ovr",   0, 1, 32'h0010_0093, 1, 32'h0000_0200, 1, 0, 0, 0, 32'h0, 32'h0);
    cyc("br_tgt",   0, 1, 32'h0000_0013, 0, 32'h0, 1, 1, 1, 1, 32'h0000_0013, 32'h200);

    // Misaligned branch to the last half-word; the PC wraps to zero.
    cyc("wrap_br",  0, 1, 32'h0,         1, 32'hFFFF_FFFE, 1, 0, 0, 0, 32'h0, 32'h0);
    cyc("wrap_mis", 0, 1, 32'h0001_0013, 0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0);
    cyc("wrap_c",   0, 0, 32'h0,         0, 32'h0, 1, 1, 0, 1, 32'h0000_0001, 32'hFFFF_FFFE);
    cyc("wrap_0",   0, 1, 32'h0000_0013, 0, 32'h0, 1, 1, 1, 1, 32'h0000_0013, 32'h0);

    // Reset while a 32-bit residue is waiting for its second half.
    cyc("res_in",   0, 1, 32'h0013_0001, 0, 32'h0, 1, 1, 1, 1, 32'h0000_0001, 32'h4);
    cyc("res_wait", 0, 0, 32'h0,         0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
    cyc("res_rst",  1, 1, 32'h0001_0001, 0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
    cyc("post_rst", 0, 1, 32'h0001_0001, 0, 32'h0, 1, 1, 1, 1, 32'h0000_0001, 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_instr_aligner.md
# cv32e40p_instr_aligner

Realigns the word-aligned 32-bit fetch stream into individual RV32IC instructions (16- or 32-bit) and presents them, one per cycle, to the compressed decoder / `cv32e40p_decoder` path in the ID stage. It holds the upper half-word of a fetch word across cycles, so that misaligned 32-bit instructions spanning two fetch words are stitched into one instruction. It also tracks the instruction PC and handles branch redirects to half-word-aligned targets. It is also used standalone as the stimulus front-end for the MCY decoder mutation bench.

## Interface
- `BOOT_ADDR`, default `32'h0000_0080`: PC loaded at reset; bit 0 ignored.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_valid_i`  in  1  fetch word valid.
- `fetch_rdata_i`  in  32  word-aligned fetch data; must be held stable while `fetch_valid_i`=1 and `fetch_ready_o`=0.
- `fetch_ready_o`  out  1  the fetch word is consumed this cycle.
- `branch_i`  in  1  redirect request; highest priority.
- `branch_addr_i`  in  32  redirect target; bit 0 ignored, bit 1 selects half-word.
- `instr_valid_o`  out  1  instruction available.
- `instr_ready_i`  in  1  downstream accepts the instruction.
- `instr_rdata_o`  out  32  instruction; compressed instructions are zero-extended as `{16'h0, half}`.
- `instr_compressed_o`  out  1  `instr_rdata_o[1:0] != 2'b11`.
- `instr_addr_o`  out  32  PC of the presented instruction; bit 0 is always 0.

## Operation
The block holds the following registers:
- `state` ∈ {ALIGNED, RESIDUE, MISALIGNED}
- `pc[31:1]`
- `residue[15:0]`

Transfer condition: `xfer = instr_valid_o & instr_ready_i`.

**ALIGNED** (next instruction starts at the lower half of the incoming word W):
- `instr_valid_o = fetch_valid_i`.
- If `W[1:0] == 11`:
  - Output W.
  - On `xfer`: `fetch_ready_o = 1`, `pc += 4`, stay in ALIGNED.
- Otherwise:
  - Output `{16'h0, W[15:0]}`.
  - On `xfer`: `fetch_ready_o = 1`, `residue <= W[31:16]`, `pc += 2`, go to RESIDUE.

**RESIDUE** (next instruction starts in `residue`):
- If `residue[1:0] != 11`:
  - `instr_valid_o = 1` regardless of `fetch_valid_i`; output `{16'h0, residue}`.
  - On `xfer`: `pc += 2`, go to ALIGNED.
  - `fetch_ready_o = 0`; the fetch word is not consumed.
- Otherwise:
  - `instr_valid_o = fetch_valid_i`; output `{W[15:0], residue}`.
  - On `xfer`: `fetch_ready_o = 1`, `residue <= W[31:16]`, `pc += 4`, stay in RESIDUE.

**MISALIGNED** (entered after a redirect to a target with bit 1 = 1):
- `instr_valid_o = 0` and `fetch_ready_o = fetch_valid_i`.
- When the word is consumed: `residue <= W[31:16]`, go to RESIDUE. The lower half-word is discarded.

**Branch** (`branch_i = 1`):
- `instr_valid_o = 0` and `fetch_ready_o = 0` in that cycle.
- `pc <= branch_addr_i[31:1]`, `residue <= 0`.
- `state <= branch_addr_i[1] ? MISALIGNED : ALIGNED`.
- From the next cycle, upstream presents the word containing the target.

PC arithmetic:
- The PC is 31 bits wide (`[31:1]`) and wraps modulo 2^32 with no flag; `32'hFFFF_FFFE + 2 = 32'h0000_0000`.
- The increment is applied only on `xfer`.

## Timing
- Reset: `state = ALIGNED`, `pc = BOOT_ADDR`, `residue = 0`.
  - During reset `instr_valid_o = 0` and `fetch_ready_o = 0`.
  - `instr_rdata_o`, `instr_addr_o` and `instr_compressed_o` are don't-care but deterministic (reset registers / the current W).
- Reset asserted mid-stall discards any held residue; there are no outputs in that cycle.
- `instr_valid_o`, `instr_rdata_o` and `fetch_ready_o` are combinational from the state registers, `fetch_*_i` and `instr_ready_i`. There is no registered latency from fetch to output.
- Throughput is one instruction per cycle in ALIGNED and RESIDUE.
- A redirect costs one bubble cycle (the branch cycle) plus one extra bubble when the target is misaligned (the MISALIGNED cycle).
- Stall: while `instr_valid_o = 1` and `instr_ready_i = 0`, the outputs stay stable provided upstream holds `fetch_*`. No state changes.
- `branch_i` together with `xfer` in the same cycle: the branch wins and no transfer occurs. `instr_valid_o` is already 0, so `xfer` cannot be 1.
- `fetch_ready_o` never asserts without `fetch_valid_i`.

## Test plan
- **Reset and aligned 32-bit words.** Drive reset, then words `32'h0000_0013` and `32'h0010_0093`, with `instr_ready_i = 1`.
  - Expect two instructions, `instr_addr_o` = 0x80 then 0x84, `instr_compressed_o = 0`, `fetch_ready_o = 1` in both cycles.
- **Compressed pair.** Drive word `32'h0001_0001` (two `c.nop`).
  - Expect `{16'h0, 16'h0001}` at 0x80 then at 0x82. The fetch word is consumed in cycle 1; cycle 2 has `fetch_ready_o = 0`.
- **Split 32-bit instruction.** Drive word A = `32'h0013_0001`, then B = `32'hAAAA_0000`.
  - Expect `c.nop` at 0x80, then `32'h0000_0013` at 0x82 (built from `{B[15:0], A[31:16]}`).
  - `residue = 16'hAAAA` afterwards, and the state stays RESIDUE.
- **Misaligned redirect.** Pulse `branch_i` with `branch_addr_i = 32'h0000_0102`, then drive word `32'h0001_FFFF`.
  - Expect one bubble for the branch and one for the MISALIGNED cycle (the word is consumed).
  - Then `c.nop` at 0x102 without a new fetch word.
- **Back-pressure and branch override.**
  - Hold `instr_ready_i = 0` for 3 cycles on a valid 32-bit word: outputs must be stable, `fetch_ready_o = 0`, and the PC is unchanged.
  - Then assert `branch_i` with `instr_ready_i = 1`: no transfer, and the PC equals the target next cycle.
- **Wrap-around and reset mid-residue.**
  - Branch to `32'hFFFF_FFFE` with a compressed instruction there: the next `instr_addr_o` is 0x0.
  - Assert `rst` while in RESIDUE: the next cycle has `state = ALIGNED` and PC = 0x80.
